inst_fetch: RTL

- Fetch-side initiator for the instruction ROM. Owns the PC and drives the ROM chip enable and byte address.
- Samples the ROM's same-cycle (combinational) instruction word and registers the PC/instruction pair into the IF/ID boundary.
- Handles pipeline stall, flush/exception redirect, branch redirect, misaligned-PC detection and a retired-fetch counter.
- Sits between the ctrl block, the ID-stage branch logic and the instruction ROM.

---
 rtl/inst_fetch.sv | 115 +++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: fetch-side initiator for the instruction ROM.
// Owns the PC, drives ROM chip enable/address, samples the ROM's same-cycle
// instruction word and registers the PC/instruction pair into IF/ID.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall[5:0]               ctrl stall vector (bit0 PC, bit1 IF, bit2 ID)
//   flush, new_pc            exception flush and its redirect target
//   branch_flag_i            taken branch/jump resolved in ID
//   branch_target_address_i  branch/jump target
//   rom_ce_o, rom_addr_o     ROM chip enable and byte address (= PC)
//   rom_inst_i               ROM data, combinational w.r.t. rom_addr_o
//   id_pc_o, id_inst_o       registered PC/instruction handed to ID
//   id_valid_o, id_adel_o    real-fetch flag, misaligned-fetch flag
//   fetch_cnt_o              count of fetches accepted into IF/ID
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_address_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o,
  output logic              id_adel_o,
  output logic [31:0]       fetch_cnt_o
);

  typedef enum logic {
    FETCH_OFF,
    FETCH_ON
  } fetch_state_t;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              misaligned;
  logic [INST_W-1:0] inst_eff;
  logic              capture;
  logic              bubble;
  logic              stall_unused;

  // Only the PC/IF/ID stall bits matter at this stage.
  assign stall_unused = ^stall[5:3];

  // Enable sequencing: the first edge out of reset only turns the ROM on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_OFF;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      FETCH_OFF: state_d = FETCH_ON;
      FETCH_ON: begin
        if (flush) begin
          pc_d = new_pc;
        end else if (!stall[0]) begin
          // A branch arriving while the PC stage is stalled is dropped;
          // ctrl keeps ID stalled so it is re-presented.
          pc_d = branch_flag_i ? branch_target_address_i : pc_q + ADDR_W'(4);
        end
      end
      default: state_d = FETCH_OFF;
    endcase
  end

  assign rom_ce_o   = (state_q == FETCH_ON);
  assign rom_addr_o = pc_q;

  // Misaligned fetches still address the ROM but the word is discarded.
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign inst_eff   = (rom_ce_o && !misaligned) ? rom_inst_i : '0;

  assign bubble  = stall[1] && !stall[2];
  assign capture = !flush && !stall[1];

  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      id_pc_o    <= '0;
      id_inst_o  <= '0;
      id_valid_o <= 1'b0;
      id_adel_o  <= 1'b0;
    end else if (capture) begin
      id_pc_o    <= pc_q;
      id_inst_o  <= inst_eff;
      id_valid_o <= rom_ce_o;
      id_adel_o  <= rom_ce_o && misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_o <= '0;
    end else if (capture && rom_ce_o) begin
      fetch_cnt_o <= fetch_cnt_o + 32'd1;
    end
  end

endmodule
